traffic_intersection_ctrl: RTL

Sequencing controller for a two-road intersection: a main road, a side road and a pedestrian crossing. It replaces free-running single-road light timing with a demand-driven scheduler. Main road rests on green. Side-road car demand and pedestrian button demand are latched and served in turn. All durations are counted in tics, qualified by a tic strobe from the existing clock divider.

---
 rtl/traffic_intersection_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl: demand-driven main/side/pedestrian intersection sequencer
module traffic_intersection_ctrl #(
  parameter int TW = 16,
  parameter int MIN_MAIN_TICS = 60,
  parameter int SIDE_GREEN_TICS = 100,
  parameter int AMBER_TICS = 30,
  parameter int CLEAR_TICS = 10,
  parameter int WALK_TICS = 50
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       tic_en,
  input  logic       side_car,
  input  logic       ped_btn,
  output logic       main_red,
  output logic       main_amber,
  output logic       main_green,
  output logic       side_red,
  output logic       side_amber,
  output logic       side_green,
  output logic       walk,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    MAIN_GREEN = 3'd0,
    MAIN_AMBER = 3'd1,
    CLR_A      = 3'd2,
    SIDE_GREEN = 3'd3,
    SIDE_AMBER = 3'd4,
    CLR_B      = 3'd5,
    WALK       = 3'd6
  } st_t;
  localparam logic [TW-1:0] MM_L = TW'((MIN_MAIN_TICS == 0 ? 1 : MIN_MAIN_TICS) - 1);
  localparam logic [TW-1:0] SG_L = TW'((SIDE_GREEN_TICS == 0 ? 1 : SIDE_GREEN_TICS) - 1);
  localparam logic [TW-1:0] AM_L = TW'((AMBER_TICS == 0 ? 1 : AMBER_TICS) - 1);
  localparam logic [TW-1:0] CL_L = TW'((CLEAR_TICS == 0 ? 1 : CLEAR_TICS) - 1);
  localparam logic [TW-1:0] WK_L = TW'((WALK_TICS == 0 ? 1 : WALK_TICS) - 1);
  st_t st, st_n;
  logic [TW-1:0] timer, timer_n, lim;
  logic side_pend, side_pend_n, ped_pend, ped_pend_n, done;
  // state, phase timer and demand latches; reset discards pending requests
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      st <= MAIN_GREEN;
      timer <= '0;
      side_pend <= 1'b0;
      ped_pend <= 1'b0;
    end else begin
      st <= st_n;
      timer <= timer_n;
      side_pend <= side_pend_n;
      ped_pend <= ped_pend_n;
    end
  end
  // phase sequencing; a phase ends on the tic that completes its last count
  always_comb begin
    st_n = st;
    lim = (st == MAIN_GREEN) ? MM_L :
          (st == MAIN_AMBER || st == SIDE_AMBER) ? AM_L :
          (st == CLR_A || st == CLR_B) ? CL_L :
          (st == SIDE_GREEN) ? SG_L : WK_L;
    done = tic_en && (timer == lim);
    case (st)
      MAIN_GREEN: st_n = (done && (side_pend || ped_pend)) ? MAIN_AMBER : MAIN_GREEN;
      MAIN_AMBER: st_n = done ? CLR_A : MAIN_AMBER;
      CLR_A:      st_n = done ? (side_pend ? SIDE_GREEN : WALK) : CLR_A;
      SIDE_GREEN: st_n = done ? SIDE_AMBER : SIDE_GREEN;
      SIDE_AMBER: st_n = done ? CLR_B : SIDE_AMBER;
      CLR_B:      st_n = done ? (ped_pend ? WALK : MAIN_GREEN) : CLR_B;
      WALK:       st_n = done ? MAIN_GREEN : WALK;
      default:    st_n = MAIN_GREEN;
    endcase
    timer_n = (st_n != st) ? '0 :
              (tic_en && !(st == MAIN_GREEN && timer == MM_L)) ? timer + 1'b1 : timer;
    side_pend_n = (st_n == SIDE_GREEN && st != SIDE_GREEN) ? 1'b0 : (side_pend | side_car);
    ped_pend_n = (st_n == WALK && st != WALK) ? 1'b0 : (ped_pend | ped_btn);
  end
  assign main_green = (st == MAIN_GREEN);
  assign main_amber = (st == MAIN_AMBER);
  assign main_red = !(main_green || main_amber);
  assign side_green = (st == SIDE_GREEN);
  assign side_amber = (st == SIDE_AMBER);
  assign side_red = !(side_green || side_amber);
  assign walk = (st == WALK);
  assign state = st;
endmodule
